seg7_tick_decoder: RTL and testbench
====================================

SEG7_TICK_DECODER -- requirements
Module: seg7_tick_decoder

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The module SHALL have parameter TICK_HZ, default 1000, meaning the strobe rate in Hz.
REQ-003 The module SHALL have port clk, input, 1 bit, the single system clock; all state on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port ce1ms, output, 1 bit, one-clock-wide strobe once per tick period.
REQ-006 The module SHALL have port dig, input, 4 bits, hex digit to display.
REQ-007 The module SHALL have port seg, output, 7 bits, segment drive with seg[0]=a through seg[6]=g, active-low (0 = lit).

Function
REQ-008 The module SHALL derive DIV = CLK_HZ/TICK_HZ (integer division); DIV < 2 SHALL be a elaboration-time error.
REQ-009 The module SHALL hold a counter of width clog2(DIV), counting 0..DIV-1 and wrapping DIV-1 -> 0, incrementing on every rising clk edge.
REQ-010 ce1ms SHALL be a registered output, set on an edge where the counter value before the edge equals DIV-1, cleared on every other edge.
REQ-011 After reset release, ce1ms SHALL first be high in the clock cycle following rising edge number DIV (with the default parameters, edge 100000), and then every DIV edges.
REQ-012 ce1ms SHALL be high for exactly one clock cycle per period and SHALL never be high on consecutive cycles.
REQ-013 ce1ms SHALL be glitch-free (driven directly from a flop), so downstream logic can use it as a clock enable or edge source.
REQ-014 seg SHALL be a purely combinational function of dig, with zero-cycle latency and no dependence on clk or rst_n.
REQ-015 seg SHALL use these hex patterns, listed as seg[6:0] in hex:
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
REQ-016 An X or Z on dig SHALL NOT be required to produce a defined seg value, but all 16 defined codes SHALL decode exactly as REQ-015.

Reset
REQ-017 While rst_n=0, the counter SHALL be 0 and ce1ms SHALL be 0, taking effect immediately without waiting for a clk edge.
REQ-018 Asserting rst_n mid-period SHALL abort the period.
REQ-019 After a mid-period reset, the first strobe SHALL occur a full DIV edges after release.
REQ-020 Reset SHALL NOT affect seg.

Verification
REQ-021 The bench SHALL cover the strobe period: with CLK_HZ=10 and TICK_HZ=1 (DIV=10), release reset and run 35 edges -> ce1ms is high only after edges 10, 20 and 30, and is 0 at all other times.
REQ-022 The bench SHALL cover strobe width: with default parameters, sample ce1ms over 300000 cycles -> exactly 3 single-cycle pulses, spaced exactly 100000 cycles apart.
REQ-023 The bench SHALL cover asynchronous reset: with DIV=10, drive rst_n low between clock edges after edge 7 -> counter and ce1ms read 0 before the next edge.
REQ-024 The bench SHALL cover reset recovery: after release following the REQ-023 reset, the next pulse follows edge 10 counted from release, not edge 3.
REQ-025 The bench SHALL cover the decoder sweep: apply dig=0..F -> seg equals the REQ-015 table in the same delta cycle (for example dig=8 -> 00, dig=1 -> 79, dig=F -> 0E).
REQ-026 The bench SHALL cover decoder independence: hold rst_n=0 and toggle dig=3 then A -> seg=30 then 08.

Source files
------------

// File: rtl/seg7_tick_decoder.sv
// Free-running tick strobe (one clk wide, every CLK_HZ/TICK_HZ edges) plus a
// combinational hex-to-7-segment decoder with active-low segment outputs.
module seg7_tick_decoder #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       ce1ms,
    input  logic [3:0] dig,
    output logic [6:0] seg
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("seg7_tick_decoder: CLK_HZ/TICK_HZ must be at least 2");
        end
    endgenerate

    logic [CW-1:0] cnt;

    // Strobe is registered so it can safely feed enables or edge detectors downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            ce1ms <= 1'b0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            ce1ms <= 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
            ce1ms <= 1'b0;
        end
    end

    // Patterns are seg[6:0] = {g,f,e,d,c,b,a}, 0 = lit.
    always_comb begin
        seg = 7'h7f;
        case (dig)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'ha:    seg = 7'h08;
            4'hb:    seg = 7'h03;
            4'hc:    seg = 7'h46;
            4'hd:    seg = 7'h21;
            4'he:    seg = 7'h06;
            4'hf:    seg = 7'h0e;
            default: seg = 7'h7f;
        endcase
    end

endmodule

// File: tb/tb_seg7_tick_decoder.sv
// Directed bench: strobe period, width, async reset/recovery and decoder table.
module tb_seg7_tick_decoder;

    logic       clk;
    logic       rst_n;
    logic       rst_n_b;
    logic [3:0] dig;
    logic       ce_a;
    logic       ce_b;
    logic [6:0] seg_a;
    logic [6:0] seg_b;

    int errors = 0;
    int checks = 0;

    // DIV = 10
    seg7_tick_decoder #(.CLK_HZ(10), .TICK_HZ(1)) u_d10 (
        .clk(clk), .rst_n(rst_n), .ce1ms(ce_a), .dig(dig), .seg(seg_a)
    );

    // DIV = 100, scaled stand-in for the width/spacing run
    seg7_tick_decoder #(.CLK_HZ(1000), .TICK_HZ(10)) u_d100 (
        .clk(clk), .rst_n(rst_n_b), .ce1ms(ce_b), .dig(dig), .seg(seg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int first_edge;
        int last_edge;
        int prev_ce;
        int bad_gap;
        int consec;

        tbl[0]  = '{4'h0, 7'h40};  tbl[1]  = '{4'h1, 7'h79};
        tbl[2]  = '{4'h2, 7'h24};  tbl[3]  = '{4'h3, 7'h30};
        tbl[4]  = '{4'h4, 7'h19};  tbl[5]  = '{4'h5, 7'h12};
        tbl[6]  = '{4'h6, 7'h02};  tbl[7]  = '{4'h7, 7'h78};
        tbl[8]  = '{4'h8, 7'h00};  tbl[9]  = '{4'h9, 7'h10};
        tbl[10] = '{4'ha, 7'h08};  tbl[11] = '{4'hb, 7'h03};
        tbl[12] = '{4'hc, 7'h46};  tbl[13] = '{4'hd, 7'h21};
        tbl[14] = '{4'he, 7'h06};  tbl[15] = '{4'hf, 7'h0e};

        rst_n   = 1'b0;
        rst_n_b = 1'b0;
        dig     = 4'h0;

        // Reset state held across several edges
        repeat (3) tick();
        check("reset_ce", 32'(ce_a), 32'd0);
        check("reset_cnt", 32'(u_d10.cnt), 32'd0);
        check("reset_ce_b", 32'(ce_b), 32'd0);

        // Decoder independence while in reset
        dig = 4'h3;
        #1;
        check("rst_seg_3", 32'(seg_a), 32'h30);
        dig = 4'ha;
        #1;
        check("rst_seg_a", 32'(seg_a), 32'h08);

        // Decoder sweep
        for (int i = 0; i < 16; i++) begin
            dig = tbl[i].dig;
            #1;
            check($sformatf("seg_dig%0h", tbl[i].dig), 32'(seg_a), 32'(tbl[i].seg));
            check($sformatf("segb_dig%0h", tbl[i].dig), 32'(seg_b), 32'(tbl[i].seg));
        end

        // Period, DIV=10: release between edges, strobe after edges 10, 20, 30
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 35; e++) begin
            tick();
            check($sformatf("period_e%0d", e), 32'(ce_a), (e % 10 == 0) ? 32'd1 : 32'd0);
        end

        // Async reset mid-period
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) tick();
        check("pre_async_cnt", 32'(u_d10.cnt), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_cnt", 32'(u_d10.cnt), 32'd0);
        check("async_ce", 32'(ce_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check($sformatf("recover_e%0d", e), 32'(ce_a), (e == 10) ? 32'd1 : 32'd0);
        end

        // Width/spacing, DIV=100, 300 cycles -> 3 single-cycle pulses
        pulses     = 0;
        first_edge = 0;
        last_edge  = 0;
        prev_ce    = 0;
        bad_gap    = 0;
        consec     = 0;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (ce_b === 1'b1) begin
                if (prev_ce != 0) consec++;
                if (pulses == 0) first_edge = e;
                else if (e - last_edge != 100) bad_gap++;
                last_edge = e;
                pulses++;
                prev_ce = 1;
            end else begin
                prev_ce = 0;
            end
        end
        check("width_pulses", 32'(pulses), 32'd3);
        check("width_first", 32'(first_edge), 32'd100);
        check("width_last", 32'(last_edge), 32'd300);
        check("width_gap", 32'(bad_gap), 32'd0);
        check("width_consec", 32'(consec), 32'd0);
        tick();
        check("width_after", 32'(ce_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
